// File: rtl/scan_decoder_pkg.sv
// Shared constants and sizing helper for the scan decoder.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Dwell counter width: max(1, clog2(hold)).
    function automatic int dcnt_width(input int hold);
        return (hold <= 2) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with enable.
module onehot_dec #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [2**N-1:0]   onehot
);

    localparam int W = 2**N;

    assign onehot = en ? (W'(1) << sel) : '0;

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and auto-scan modes.
// Scan position advances every HOLD_CYCLES enabled cycles; wrap pulses on rollover.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N           = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic             dir,
    input  logic [N-1:0]     in,
    output logic [2**N-1:0]  out,
    output logic [N-1:0]     idx,
    output logic             wrap
);

    localparam int             DW        = dcnt_width(HOLD_CYCLES);
    localparam logic [DW-1:0]  DCNT_LAST = DW'(HOLD_CYCLES - 1);
    localparam logic [N-1:0]   IDX_MAX   = '1;

    logic [DW-1:0] dcnt;
    logic          act;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            dcnt <= '0;
            act  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            act <= en;
            if (!en) begin
                wrap <= 1'b0;
            end else if (mode == MODE_DIRECT || load) begin
                idx  <= in;
                dcnt <= '0;
                wrap <= 1'b0;
            end else if (dcnt != DCNT_LAST) begin
                dcnt <= dcnt + DW'(1);
                wrap <= 1'b0;
            end else begin
                // End of dwell: step, flag rollover in the direction of travel.
                dcnt <= '0;
                if (dir == DIR_UP) begin
                    idx  <= idx + N'(1);
                    wrap <= (idx == IDX_MAX);
                end else begin
                    idx  <= idx - N'(1);
                    wrap <= (idx == '0);
                end
            end
        end
    end

    onehot_dec #(.N(N)) u_dec (
        .sel    (idx),
        .en     (act),
        .onehot (out)
    );

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: three decoder configurations driven by shared stimulus.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] in_v = '0;

    logic [1:0] idx0;
    logic [3:0] out0;
    logic       wrap0;
    logic [2:0] idx1, idx2;
    logic [7:0] out1, out2;
    logic       wrap1, wrap2;

    logic [2:0] idx_o [3];
    logic [7:0] out_o [3];
    logic       wrap_o[3];

    int total = 0;
    int bad   = 0;

    // reference model state per instance
    int nn[3] = '{2, 3, 3};
    int hh[3] = '{3, 1, 4};
    int pos[3];
    int cnt[3];
    bit act_m[3];
    bit wrp_m[3];

    always #5 clk = ~clk;

    scan_decoder #(.N(2), .HOLD_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .dir(dir),
        .in(in_v[1:0]), .out(out0), .idx(idx0), .wrap(wrap0));
    scan_decoder #(.N(3), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .dir(dir),
        .in(in_v), .out(out1), .idx(idx1), .wrap(wrap1));
    scan_decoder #(.N(3), .HOLD_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .dir(dir),
        .in(in_v), .out(out2), .idx(idx2), .wrap(wrap2));

    assign idx_o[0]  = {1'b0, idx0};
    assign idx_o[1]  = idx1;
    assign idx_o[2]  = idx2;
    assign out_o[0]  = {4'b0, out0};
    assign out_o[1]  = out1;
    assign out_o[2]  = out2;
    assign wrap_o[0] = wrap0;
    assign wrap_o[1] = wrap1;
    assign wrap_o[2] = wrap2;

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            int m;
            m = 1 << nn[d];
            if (rst) begin
                pos[d] = 0; cnt[d] = 0; act_m[d] = 0; wrp_m[d] = 0;
            end else begin
                act_m[d] = en;
                if (!en) begin
                    wrp_m[d] = 0;
                end else if (!mode || load) begin
                    pos[d] = int'(in_v) % m; cnt[d] = 0; wrp_m[d] = 0;
                end else if (cnt[d] < hh[d] - 1) begin
                    cnt[d] = cnt[d] + 1; wrp_m[d] = 0;
                end else begin
                    cnt[d] = 0;
                    if (!dir) begin
                        wrp_m[d] = (pos[d] == m - 1);
                        pos[d] = (pos[d] + 1) % m;
                    end else begin
                        wrp_m[d] = (pos[d] == 0);
                        pos[d] = (pos[d] + m - 1) % m;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_out(int d);
        return act_m[d] ? 8'(1 << pos[d]) : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_v = 3'd5;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (out_o[d] !== 8'h00 || idx_o[d] !== 3'd0 || wrap_o[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d got out=%h idx=%0d wrap=%b want 00/0/0",
                         d, out_o[d], idx_o[d], wrap_o[d]);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (out_o[1] !== 8'h20) begin
            bad++; $display("FAIL reset_release dut1 got out=%h want 20", out_o[1]);
        end
        total++;
        if (out_o[0] !== 8'h02) begin
            bad++; $display("FAIL reset_release dut0 got out=%h want 02", out_o[0]);
        end
    endtask

    task automatic test_direct_sweep();
        mode = 1'b0; en = 1'b1; load = 1'b0;
        for (int v = 0; v < 4; v++) begin
            in_v = 3'(v);
            tick();
            total++;
            if (out_o[0] !== 8'(1 << v) || idx_o[0] !== 3'(v)) begin
                bad++;
                $display("FAIL direct_sweep v=%0d got out=%h idx=%0d want out=%h idx=%0d",
                         v, out_o[0], idx_o[0], 8'(1 << v), v);
            end
        end
        en = 1'b0;
        tick();
        total++;
        if (out_o[0] !== 8'h00 || idx_o[0] !== 3'd3) begin
            bad++;
            $display("FAIL direct_disable got out=%h idx=%0d want out=00 idx=3",
                     out_o[0], idx_o[0]);
        end
    endtask

    task automatic test_scan_up_wrap();
        int seq[7];
        bit wseq[7];
        seq  = '{2, 2, 2, 3, 3, 3, 0};
        wseq = '{0, 0, 0, 0, 0, 0, 1};
        en = 1'b1; mode = 1'b1; load = 1'b1; dir = 1'b0; in_v = 3'd2;
        for (int i = 0; i < 7; i++) begin
            tick();
            load = 1'b0;
            total++;
            if (idx_o[0] !== 3'(seq[i]) || wrap_o[0] !== wseq[i]) begin
                bad++;
                $display("FAIL scan_up step=%0d got idx=%0d wrap=%b want idx=%0d wrap=%b",
                         i, idx_o[0], wrap_o[0], seq[i], wseq[i]);
            end
        end
        tick();
        total++;
        if (wrap_o[0] !== 1'b0 || idx_o[0] !== 3'd0) begin
            bad++;
            $display("FAIL scan_up_wrap_pulse got idx=%0d wrap=%b want idx=0 wrap=0",
                     idx_o[0], wrap_o[0]);
        end
    endtask

    task automatic test_scan_down_pause();
        en = 1'b1; mode = 1'b1; load = 1'b1; dir = 1'b1; in_v = 3'd1;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (idx_o[1] !== 3'd0 || wrap_o[1] !== 1'b0) begin
            bad++; $display("FAIL scan_down_0 got idx=%0d wrap=%b want 0/0", idx_o[1], wrap_o[1]);
        end
        tick();
        total++;
        if (idx_o[1] !== 3'd7 || wrap_o[1] !== 1'b1 || out_o[1] !== 8'h80) begin
            bad++;
            $display("FAIL scan_down_wrap got idx=%0d wrap=%b out=%h want 7/1/80",
                     idx_o[1], wrap_o[1], out_o[1]);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (idx_o[1] !== 3'd7 || out_o[1] !== 8'h00 || wrap_o[1] !== 1'b0) begin
                bad++;
                $display("FAIL scan_pause c=%0d got idx=%0d out=%h wrap=%b want 7/00/0",
                         i, idx_o[1], out_o[1], wrap_o[1]);
            end
        end
        en = 1'b1;
        tick();
        total++;
        if (idx_o[1] !== 3'd6 || out_o[1] !== 8'h40) begin
            bad++;
            $display("FAIL scan_resume got idx=%0d out=%h want 6/40", idx_o[1], out_o[1]);
        end
    endtask

    task automatic test_load_priority();
        en = 1'b1; mode = 1'b1; load = 1'b1; dir = 1'b0; in_v = 3'd2;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        load = 1'b1; in_v = 3'd4;
        tick();
        load = 1'b0;
        total++;
        if (idx_o[2] !== 3'd4 || wrap_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL load_priority got idx=%0d wrap=%b want 4/0", idx_o[2], wrap_o[2]);
        end
        tick(); tick(); tick();
        total++;
        if (idx_o[2] !== 3'd4) begin
            bad++; $display("FAIL load_dwell_restart got idx=%0d want 4", idx_o[2]);
        end
        tick();
        total++;
        if (idx_o[2] !== 3'd5) begin
            bad++; $display("FAIL load_then_step got idx=%0d want 5", idx_o[2]);
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; mode = 1'b1; load = 1'b1; dir = 1'b1; in_v = 3'd0;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        total++;
        if (idx_o[0] !== 3'd3 || wrap_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup got idx=%0d wrap=%b want 3/1", idx_o[0], wrap_o[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (idx_o[0] !== 3'd0 || out_o[0] !== 8'h00 || wrap_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got idx=%0d out=%h wrap=%b want 0/00/0",
                     idx_o[0], out_o[0], wrap_o[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 31) == 0);
            en   = ($urandom_range(0, 7) != 0);
            mode = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 5) == 0);
            dir  = 1'($urandom_range(0, 1));
            in_v = 3'($urandom_range(0, 7));
            tick();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (idx_o[d] !== 3'(pos[d]) || out_o[d] !== exp_out(d) ||
                    wrap_o[d] !== wrp_m[d]) begin
                    bad++;
                    $display("FAIL random i=%0d dut%0d got idx=%0d out=%h wrap=%b want idx=%0d out=%h wrap=%b",
                             i, d, idx_o[d], out_o[d], wrap_o[d], pos[d], exp_out(d), wrp_m[d]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_direct_sweep();
        test_scan_up_wrap();
        test_scan_down_pause();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
